// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 string-matching pipeline:
// driver state encoding, result status codes and command legality.
package md5_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_STREAM     = 4'd2,
    ST_WAIT_DONE  = 4'd3,
    ST_STATUS     = 4'd4,
    ST_POS_HI     = 4'd5,
    ST_POS_LO     = 4'd6,
    ST_CHAR_LOAD  = 4'd7,
    ST_CHAR_SEND  = 4'd8,
    ST_CHAR_SHIFT = 4'd9
  } state_e;

  localparam logic [7:0] CODE_NO_MATCH = 8'h00;
  localparam logic [7:0] CODE_MATCH    = 8'h01;
  localparam logic [7:0] CODE_ILLEGAL  = 8'hFE;
  localparam logic [7:0] CODE_TIMEOUT  = 8'hFF;

  localparam int unsigned MD5_MAX_MSG_BITS = 448;

  // A string length is usable only as whole, nonzero bytes within one block.
  function automatic logic str_len_legal(input logic [15:0] len,
                                         input int unsigned max_bits);
    return (len != 16'd0) && (len[2:0] == 3'd0) && (32'(len) <= max_bits);
  endfunction

endpackage

// File: rtl/proc_batch_driver.sv
// Command-side driver: issues one batch to the string processor/matcher,
// streams its bytes, waits for completion and frames the result bytes.
module proc_batch_driver
  import md5_pkg::*;
#(
  parameter int unsigned MAX_STR_BITS   = 440,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_target_hash,
  input  logic [15:0]  cmd_str_len,
  input  logic [15:0]  cmd_num_bytes,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         proc_start,
  output logic [15:0]  proc_num_bytes,
  output logic [127:0] proc_target_hash,
  output logic [15:0]  proc_str_len,
  output logic [7:0]   proc_data,
  output logic         proc_data_valid,
  output logic         proc_match_char_next,
  input  logic         proc_done,
  input  logic         proc_match,
  input  logic [15:0]  proc_byte_pos,
  input  logic [7:0]   proc_match_char
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic        TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  state_e         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           in_ready_q, in_ready_d;
  logic [127:0]   hash_q, hash_d;
  logic [15:0]    str_len_q, str_len_d;
  logic [15:0]    num_bytes_q, num_bytes_d;
  logic [12:0]    char_cnt_q, char_cnt_d;
  logic [15:0]    remaining_q, remaining_d;
  logic [15:0]    timeout_q, timeout_d;
  logic           match_q, match_d;
  logic [15:0]    byte_pos_q, byte_pos_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     proc_data_q, proc_data_d;
  logic           proc_data_valid_q, proc_data_valid_d;
  logic           proc_start_q, proc_start_d;
  logic           char_next_q, char_next_d;

  // Next-state and registered-output computation for the batch sequencer.
  always_comb begin
    state_d           = state_q;
    hash_d            = hash_q;
    str_len_d         = str_len_q;
    num_bytes_d       = num_bytes_q;
    char_cnt_d        = char_cnt_q;
    remaining_d       = remaining_q;
    timeout_d         = timeout_q;
    match_d           = match_q;
    byte_pos_d        = byte_pos_q;
    code_d            = code_q;
    out_data_d        = out_data_q;
    out_valid_d       = out_valid_q;
    proc_data_d       = proc_data_q;
    proc_data_valid_d = 1'b0;
    proc_start_d      = 1'b0;
    char_next_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          hash_d      = cmd_target_hash;
          str_len_d   = cmd_str_len;
          num_bytes_d = cmd_num_bytes;
          char_cnt_d  = cmd_str_len[15:3];
          if (str_len_legal(cmd_str_len, MAX_STR_BITS)) begin
            state_d      = ST_START;
            proc_start_d = 1'b1;
          end else begin
            state_d = ST_STATUS;
            code_d  = CODE_ILLEGAL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        remaining_d = num_bytes_q;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        // The timeout window starts fresh on every entry into WAIT_DONE.
        timeout_d = 16'd0;
        if (remaining_q == 16'd0) begin
          state_d = ST_WAIT_DONE;
        end else if (in_valid && in_ready_q) begin
          proc_data_d       = in_data;
          proc_data_valid_d = 1'b1;
          remaining_d       = remaining_q - 16'd1;
          state_d           = (remaining_q == 16'd1) ? ST_WAIT_DONE : ST_STREAM;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT_DONE: begin
        if (proc_done) begin
          match_d    = proc_match;
          byte_pos_d = proc_match ? proc_byte_pos : 16'd0;
          code_d     = proc_match ? CODE_MATCH : CODE_NO_MATCH;
          state_d    = ST_STATUS;
        end else if (TIMEOUT_EN && (timeout_q == TIMEOUT_LIMIT)) begin
          match_d = 1'b0;
          code_d  = CODE_TIMEOUT;
          state_d = ST_STATUS;
        end else begin
          timeout_d = timeout_q + 16'd1;
        end
      end
      ST_STATUS: begin
        if (!out_valid_q) begin
          out_data_d  = code_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ((code_q == CODE_MATCH) || (code_q == CODE_NO_MATCH))
                        ? ST_POS_HI : ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      ST_POS_HI: begin
        if (!out_valid_q) begin
          out_data_d  = byte_pos_q[15:8];
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_POS_LO;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      ST_POS_LO: begin
        if (!out_valid_q) begin
          out_data_d  = byte_pos_q[7:0];
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = match_q ? ST_CHAR_LOAD : ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      ST_CHAR_LOAD: begin
        out_data_d  = proc_match_char;
        out_valid_d = 1'b1;
        state_d     = ST_CHAR_SEND;
      end
      ST_CHAR_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          char_cnt_d  = char_cnt_q - 13'd1;
          if (char_cnt_q != 13'd1) begin
            char_next_d = 1'b1;
            state_d     = ST_CHAR_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      ST_CHAR_SHIFT: begin
        // The matcher advances on this cycle's pulse; sample the new char next.
        state_d = ST_CHAR_LOAD;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    in_ready_d  = (state_d == ST_STREAM) && (remaining_d != 16'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      cmd_ready_q       <= 1'b1;
      in_ready_q        <= 1'b0;
      hash_q            <= 128'd0;
      str_len_q         <= 16'd0;
      num_bytes_q       <= 16'd0;
      char_cnt_q        <= 13'd0;
      remaining_q       <= 16'd0;
      timeout_q         <= 16'd0;
      match_q           <= 1'b0;
      byte_pos_q        <= 16'd0;
      code_q            <= 8'd0;
      out_data_q        <= 8'd0;
      out_valid_q       <= 1'b0;
      proc_data_q       <= 8'd0;
      proc_data_valid_q <= 1'b0;
      proc_start_q      <= 1'b0;
      char_next_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      cmd_ready_q       <= cmd_ready_d;
      in_ready_q        <= in_ready_d;
      hash_q            <= hash_d;
      str_len_q         <= str_len_d;
      num_bytes_q       <= num_bytes_d;
      char_cnt_q        <= char_cnt_d;
      remaining_q       <= remaining_d;
      timeout_q         <= timeout_d;
      match_q           <= match_d;
      byte_pos_q        <= byte_pos_d;
      code_q            <= code_d;
      out_data_q        <= out_data_d;
      out_valid_q       <= out_valid_d;
      proc_data_q       <= proc_data_d;
      proc_data_valid_q <= proc_data_valid_d;
      proc_start_q      <= proc_start_d;
      char_next_q       <= char_next_d;
    end
  end

  assign cmd_ready            = cmd_ready_q;
  assign in_ready             = in_ready_q;
  assign out_data             = out_data_q;
  assign out_valid            = out_valid_q;
  assign proc_start           = proc_start_q;
  assign proc_num_bytes       = num_bytes_q;
  assign proc_target_hash     = hash_q;
  assign proc_str_len         = str_len_q;
  assign proc_data            = proc_data_q;
  assign proc_data_valid      = proc_data_valid_q;
  assign proc_match_char_next = char_next_q;

endmodule

// File: tb/tb_proc_batch_driver.sv
// Bench for proc_batch_driver: behavioural matcher model, scoreboarded
// result stream, a vector table, directed corner cases and random batches.
module tb_proc_batch_driver;

  localparam int TO   = 10;
  localparam int MAXB = 440;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [15:0] len;
    logic [15:0] nb;
    bit          match;
    logic [15:0] pos;
    bit          hang;
    int          delay;
    bit          bp;
    logic [7:0]  exp_code;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n, cmd_valid, cmd_ready, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] cmd_target_hash, proc_target_hash;
  logic [15:0]  cmd_str_len, cmd_num_bytes, proc_num_bytes, proc_str_len, proc_byte_pos;
  logic [7:0]   in_data, out_data, proc_data, proc_match_char;
  logic         proc_start, proc_data_valid, proc_match_char_next, proc_done, proc_match;

  proc_batch_driver #(.MAX_STR_BITS(MAXB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target_hash(cmd_target_hash), .cmd_str_len(cmd_str_len),
    .cmd_num_bytes(cmd_num_bytes), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .proc_start(proc_start), .proc_num_bytes(proc_num_bytes),
    .proc_target_hash(proc_target_hash), .proc_str_len(proc_str_len),
    .proc_data(proc_data), .proc_data_valid(proc_data_valid),
    .proc_match_char_next(proc_match_char_next), .proc_done(proc_done),
    .proc_match(proc_match), .proc_byte_pos(proc_byte_pos),
    .proc_match_char(proc_match_char)
  );

  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit is_legal(input logic [15:0] len);
    return (len != 16'd0) && (len % 16'd8 == 16'd0) && (int'(len) <= MAXB);
  endfunction

  // Reference: the complete framed result a batch must produce.
  function automatic bq_t ref_model(input logic [15:0] len, input bit match,
                                    input logic [15:0] pos, input bit hang, input bq_t chars);
    bq_t r;
    if (!is_legal(len)) r.push_back(8'hFE);
    else if (hang) r.push_back(8'hFF);
    else if (!match) begin
      r.push_back(8'h00); r.push_back(8'h00); r.push_back(8'h00);
    end else begin
      r.push_back(8'h01); r.push_back(pos[15:8]); r.push_back(pos[7:0]);
      for (int i = 0; i < int'(len) / 8; i++) r.push_back(chars[i]);
    end
    return r;
  endfunction

  // scenario for the matcher model
  bit scen_match, scen_hang;
  logic [15:0] scen_pos;
  int scen_delay;
  bq_t scen_chars, stim_bytes;

  // monitor results
  int n_start, n_dv, n_next, hold_err, cyc, hs_cyc, st_cyc, out_rise_cyc, dv_at_first_out;
  bit first_out_seen;
  bq_t got_q, rx_q;
  logic [15:0] cap_len, cap_nb, res_len, res_nb;
  logic [127:0] cap_hash, res_hash;

  // matcher model state
  bit m_busy, m_match, m_hang, start_seen, next_seen, rst_seen;
  int m_rx, m_dly;
  logic [15:0] m_num, m_pos;
  bq_t m_chars;

  initial begin
    bit prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0; prev_data = 8'h00; hold_err = 0; cyc = 0;
    m_busy = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = 1'b0; next_seen = 1'b0; rst_seen = !reset_n;
      if (reset_n) begin
        if (proc_start) begin
          n_start++; st_cyc = cyc; start_seen = 1'b1;
          cap_len = proc_str_len; cap_nb = proc_num_bytes; cap_hash = proc_target_hash;
        end
        if (proc_data_valid) begin n_dv++; m_rx++; rx_q.push_back(proc_data); end
        if (proc_match_char_next) begin n_next++; next_seen = 1'b1; end
        if (out_valid && !first_out_seen) begin
          first_out_seen = 1'b1; out_rise_cyc = cyc; dv_at_first_out = n_dv;
          res_len = proc_str_len; res_nb = proc_num_bytes; res_hash = proc_target_hash;
        end
        if (prev_hold && !(out_valid && out_data == prev_data)) hold_err++;
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (cmd_valid && cmd_ready) hs_cyc = cyc;
      end else prev_hold = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      if (rst_seen) begin
        m_busy = 1'b0; proc_done = 1'b0; proc_match = 1'b0;
        proc_byte_pos = 16'd0; proc_match_char = 8'd0;
      end else begin
        if (start_seen) begin
          proc_done = 1'b0; proc_match = 1'b0; m_busy = 1'b1; m_rx = 0;
          m_num = cap_nb; m_dly = scen_delay; m_match = scen_match;
          m_pos = scen_pos; m_hang = scen_hang; m_chars = scen_chars;
        end else if (m_busy && m_rx == int'(m_num) && !m_hang) begin
          if (m_dly == 0) begin
            proc_done = 1'b1; proc_match = m_match;
            proc_byte_pos = m_match ? m_pos : 16'd0; m_busy = 1'b0;
          end else m_dly--;
        end
        if (next_seen && m_chars.size() > 0) void'(m_chars.pop_front());
        proc_match_char = (m_chars.size() > 0) ? m_chars[0] : 8'h00;
      end
    end
  end

  task automatic begin_batch(input logic [15:0] len, input logic [15:0] nb, input logic [127:0] hash);
    bit ok;
    n_start = 0; n_dv = 0; n_next = 0; got_q.delete(); rx_q.delete();
    first_out_seen = 1'b0; hs_cyc = -100; st_cyc = -200;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_str_len = len; cmd_num_bytes = nb; cmd_target_hash = hash;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    check("cmd_accept", 128'(ok), 128'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_batch(input vec_t v, input logic [127:0] hash, input bit check_code);
    bq_t exp;
    int idx;
    bit fin, legal;
    legal = is_legal(v.len);
    exp = ref_model(v.len, v.match, v.pos, v.hang, scen_chars);
    scen_match = v.match; scen_pos = v.pos; scen_hang = v.hang; scen_delay = v.delay;
    begin_batch(v.len, v.nb, hash);
    idx = 0; fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      in_valid  = (idx < int'(v.nb)) && (!v.bp || $urandom_range(0, 3) != 0);
      in_data   = (idx < int'(v.nb)) ? stim_bytes[idx] : 8'h00;
      out_ready = !v.bp || $urandom_range(0, 2) != 0;
      @(negedge clk); #1;
      if (in_valid && in_ready) idx++;
      if (got_q.size() >= exp.size()) fin = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("batch_complete", 128'(fin), 128'd1);
    @(negedge clk);
    check("idle_cmd_ready", 128'(cmd_ready), 128'd1);
    check("idle_out_valid", 128'(out_valid), 128'd0);
    check("out_count", 128'(got_q.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("out_byte[%0d]", i), 128'(got_q[i]), 128'(exp[i]));
    if (check_code && got_q.size() > 0) check("status_code", 128'(got_q[0]), 128'(v.exp_code));
    check("start_pulses", 128'(n_start), legal ? 128'd1 : 128'd0);
    check("dv_pulses", 128'(n_dv), legal ? 128'(v.nb) : 128'd0);
    check("next_pulses", 128'(n_next),
          (legal && !v.hang && v.match) ? 128'(v.len / 16'd8 - 16'd1) : 128'd0);
    if (legal) begin
      for (int i = 0; i < rx_q.size() && i < int'(v.nb); i++)
        check($sformatf("proc_data[%0d]", i), 128'(rx_q[i]), 128'(stim_bytes[i]));
      check("start_latency", 128'(st_cyc - hs_cyc), 128'd1);
      check("hold_at_start", {cap_hash ^ hash, cap_len, cap_nb}, {128'd0, v.len, v.nb});
      check("hold_at_result", {res_hash ^ hash, res_len, res_nb}, {128'd0, v.len, v.nb});
      check("bytes_before_result", 128'(dv_at_first_out), 128'(v.nb));
    end
    // START + STREAM (empty) + TO+1 WAIT_DONE cycles + STATUS load, then visible.
    if (legal && v.hang && v.nb == 16'd0)
      check("timeout_latency", 128'(out_rise_cyc - hs_cyc), 128'(TO + 5));
  endtask

  task automatic fill_random(input logic [15:0] len, input logic [15:0] nb);
    stim_bytes.delete(); scen_chars.delete();
    for (int i = 0; i < int'(nb); i++) stim_bytes.push_back(8'($urandom));
    for (int i = 0; i < int'(len) / 8 && i < 64; i++) scen_chars.push_back(8'($urandom));
  endtask

  vec_t vecs[8];

  initial begin
    logic [127:0] abc_hash;
    logic [7:0] held;
    int bp_err;
    bit seen_v, got4;
    abc_hash = 128'h900150983cd24fb0d6963f7d28e17f72;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_target_hash = '0; cmd_str_len = '0;
    cmd_num_bytes = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    proc_done = 1'b0; proc_match = 1'b0; proc_byte_pos = '0; proc_match_char = '0;
    scen_match = 1'b0; scen_hang = 1'b0; scen_pos = '0; scen_delay = 0;

    //          len     nb     match pos     hang dly bp   code
    vecs[0] = '{16'd24,  16'd3,  1'b1, 16'd2,  1'b0, 2, 1'b0, 8'h01};
    vecs[1] = '{16'd40,  16'd5,  1'b0, 16'd0,  1'b0, 1, 1'b1, 8'h00};
    vecs[2] = '{16'd12,  16'd4,  1'b0, 16'd0,  1'b0, 0, 1'b0, 8'hFE};
    vecs[3] = '{16'd0,   16'd4,  1'b0, 16'd0,  1'b0, 0, 1'b0, 8'hFE};
    vecs[4] = '{16'd448, 16'd4,  1'b0, 16'd0,  1'b0, 0, 1'b0, 8'hFE};
    vecs[5] = '{16'd440, 16'd60, 1'b1, 16'd54, 1'b0, 3, 1'b1, 8'h01};
    vecs[6] = '{16'd16,  16'd4,  1'b0, 16'd0,  1'b0, 6, 1'b1, 8'h00};
    vecs[7] = '{16'd8,   16'd0,  1'b0, 16'd0,  1'b1, 0, 1'b0, 8'hFF};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    check("rst_outputs", {out_valid, out_data, in_ready, proc_start, proc_data_valid,
                          proc_match_char_next, proc_data, proc_str_len, proc_num_bytes},
          128'd0);
    check("rst_hash", proc_target_hash, 128'd0);

    // Vector 6 follows a match so a stale proc_done=1 is present at its START.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        stim_bytes = '{8'h61, 8'h62, 8'h63};
        scen_chars = '{8'h61, 8'h62, 8'h63};
      end else fill_random(vecs[i].len, vecs[i].nb);
      run_batch(vecs[i], (i == 0) ? abc_hash : {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    // Char-phase backpressure then reset mid-stream.
    stim_bytes = '{8'h61, 8'h62, 8'h63};
    scen_chars = '{8'h61, 8'h62, 8'h63};
    scen_match = 1'b1; scen_pos = 16'd2; scen_hang = 1'b0; scen_delay = 1;
    begin_batch(16'd24, 16'd3, abc_hash);
    got4 = 1'b0;
    for (int c = 0, idx = 0; c < 200 && !got4; c++) begin
      in_valid = idx < 3; in_data = (idx < 3) ? stim_bytes[idx] : 8'h00; out_ready = 1'b1;
      @(negedge clk); #1;
      if (in_valid && in_ready) idx++;
      if (got_q.size() >= 4) got4 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_reach_char", 128'(got4), 128'd1);
    seen_v = 1'b0; held = 8'h00; bp_err = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (seen_v && !(out_valid && out_data == held)) bp_err++;
      if (out_valid && !seen_v) begin seen_v = 1'b1; held = out_data; end
    end
    check("bp_valid", 128'(out_valid), 128'd1);
    check("bp_data", 128'(held), 128'h62);
    check("bp_stable", 128'(bp_err), 128'd0);
    check("bp_next_pulses", 128'(n_next), 128'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {out_valid, out_data, in_ready, proc_start, proc_data_valid,
                             proc_match_char_next, proc_str_len, proc_num_bytes}, 128'd0);
    check("midrst_cmd_ready", 128'(cmd_ready), 128'd1);
    @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("postrst_idle", {cmd_ready, out_valid}, 128'h2);

    // Random batches against the reference model.
    for (int r = 0; r < 25; r++) begin
      vec_t v;
      v.len   = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 500))
                                            : 16'(8 * $urandom_range(1, 55));
      v.nb    = 16'($urandom_range(0, 12));
      v.match = 1'($urandom_range(0, 1));
      v.pos   = 16'($urandom);
      v.hang  = ($urandom_range(0, 7) == 0);
      v.delay = $urandom_range(0, 6);
      v.bp    = 1'b1;
      v.exp_code = 8'h00;
      fill_random(v.len, v.nb);
      run_batch(v, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    check("out_hold_violations", 128'(hold_err), 128'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
